onchip_mem_loader: RTL and testbench
====================================

ONCHIP_MEM_LOADER -- requirements
Module: onchip_mem_loader

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 7, word-address width of the target on-chip RAM.
- REQ-002 SHALL have parameter DEPTH, default 128, number of 32-bit words in the target RAM.
- REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
- REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
- REQ-006 SHALL have port in_data  input  8  stream byte.
- REQ-007 SHALL have port in_valid  input  1  in_data valid.
- REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid & in_ready.
- REQ-009 SHALL have port address  output  ADDR_WIDTH  RAM word address.
- REQ-010 SHALL have port byteenable  output  4  RAM byte enables.
- REQ-011 SHALL have port chipselect  output  1  RAM select.
- REQ-012 SHALL have port write  output  1  RAM write strobe.
- REQ-013 SHALL have port writedata  output  32  RAM write data.
- REQ-014 SHALL have port clken  output  1  RAM clock enable.
- REQ-015 SHALL have port readdata  input  32  RAM read data, valid one cycle after address is presented with chipselect.
- REQ-016 SHALL have ports busy, done, error  output  1 each  status.

Function
- REQ-017 States SHALL be IDLE, ADDR, COUNT, DATA, WRITE, CHECK, RDBK, DRAIN, DONE.
- REQ-018 IDLE: start=1 -> ADDR; clears error, running sums, byte index. start outside IDLE SHALL be ignored.
- REQ-019 in_ready SHALL be 1 only in ADDR, COUNT, DATA, CHECK; 0 in all other states.
- REQ-020 ADDR: accepted byte[ADDR_WIDTH-1:0] -> base/current word address; -> COUNT.
- REQ-021 COUNT: accepted byte = word count N; N=0 or N>DEPTH -> error=1, -> DONE; else -> DATA.
- REQ-022 DATA: bytes little-endian (first byte -> writedata[7:0]); each byte added mod 256 to the stream sum; 4th byte -> WRITE.
- REQ-023 WRITE: exactly one cycle, chipselect=1, write=1, byteenable=4'hF, address=current, writedata=assembled word; then address increments mod DEPTH (127 -> 0 at default), words-remaining decrements; remaining>0 -> DATA, else CHECK.
- REQ-024 CHECK: accepted byte = expected checksum; error set if it differs from stream sum; address reloads base; -> RDBK.
- REQ-025 RDBK: N consecutive cycles, chipselect=1, write=0, address incrementing mod DEPTH; readdata of each word SHALL be sampled the following cycle and its four bytes summed mod 256 into readback sum.
- REQ-026 DRAIN: one cycle capturing the last readdata; then error |= (readback sum != expected checksum); -> DONE.
- REQ-027 DONE: done=1 for exactly one cycle, -> IDLE; error SHALL hold until next accepted start or reset.
- REQ-028 busy SHALL be 1 in every state except IDLE.
- REQ-029 clken SHALL be constant 1; byteenable SHALL be 4'hF whenever chipselect=1, else 0.
- REQ-030 chipselect and write SHALL be 0 in all states not stated above; in_valid=0 stalls the FSM indefinitely with no RAM access.
- REQ-031 Wrap-around: a load with base+N > DEPTH SHALL continue at word 0, both in WRITE and RDBK.

Reset
- REQ-032 reset=1 at any clock edge, including mid-load, SHALL force IDLE and drive in_ready, chipselect, write, busy, done, error, address, writedata, byteenable to 0, discarding any partial word; no RAM write occurs on that cycle.

Verification
- REQ-033 Load base=0x10, N=2, words 0x04030201, 0x08070605, checksum 0x24 -> writes at 0x10,0x11 with those values, readback 2 cycles, done pulse, error=0.
- REQ-034 Same as REQ-033 but checksum 0x25 -> all writes still occur, done pulse, error=1.
- REQ-035 base=0x7F, N=2 -> writes to 0x7F then 0x00; readback addresses 0x7F, 0x00; error=0.
- REQ-036 COUNT byte 0x00, then separately 0x81 -> no write ever asserted, done pulse, error=1 both times.
- REQ-037 Assert reset after 2 bytes of the first data word -> next cycle busy=0, write=0, in_ready=0; a fresh load then succeeds with error=0.
- REQ-038 Randomly deassert in_valid and pulse start while busy -> written words and checksum result identical to gap-free stream; extra start has no effect.

Source files
------------

// File: rtl/onchip_mem_loader_if.sv
// Byte-stream input and on-chip RAM port bundle for the memory loader.
interface onchip_mem_loader_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [3:0]            byteenable;
  logic                  chipselect;
  logic                  write;
  logic [31:0]           writedata;
  logic                  clken;
  logic [31:0]           readdata;

  // Loader side: consumes the byte stream, masters the RAM.
  modport master (
    input  in_data, in_valid, readdata,
    output in_ready, address, byteenable, chipselect, write, writedata, clken
  );

  // Environment side: produces the byte stream, models the RAM.
  modport slave (
    output in_data, in_valid, readdata,
    input  in_ready, address, byteenable, chipselect, write, writedata, clken
  );
endinterface

// File: rtl/onchip_mem_loader.sv
// Loads a checksummed byte stream into on-chip RAM as 32-bit words, then
// reads the words back and verifies the stored data against the checksum.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | take base word address byte
// COUNT | take word count byte, reject 0 or > DEPTH
// DATA  | assemble four little-endian bytes into a word
// WRITE | one-cycle RAM write of the assembled word
// CHECK | take expected checksum byte, compare with stream sum
// RDBK  | issue N reads starting at base
// DRAIN | capture last read word, final readback compare
// DONE  | one-cycle done pulse
module onchip_mem_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  onchip_mem_loader_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [3:0] {
    IDLE, ADDR, COUNT, DATA, WRITE, CHECK, RDBK, DRAIN, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, cur_q;
  logic [7:0]            n_q, remaining_q, rd_left_q;
  logic [1:0]            idx_q;
  logic [31:0]           word_q;
  logic [7:0]            sum_q, rb_sum_q, exp_q;
  logic                  rd_pend_q;
  logic                  error_q;

  logic                  acc;
  logic                  cnt_bad;
  logic [7:0]            rd_bytes;
  logic [7:0]            rb_sum_nxt;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) == DEPTH - 1) return '0;
    else return a + 1'b1;
  endfunction

  assign acc        = bus.in_valid & bus.in_ready;
  assign cnt_bad    = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH);
  assign rd_bytes   = bus.readdata[7:0] + bus.readdata[15:8] +
                      bus.readdata[23:16] + bus.readdata[31:24];
  assign rb_sum_nxt = rb_sum_q + rd_bytes;

  assign bus.address   = cur_q;
  assign bus.writedata = word_q;
  assign bus.clken     = 1'b1;
  assign error         = error_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived handshake/RAM strobes.
  always_comb begin
    state_d        = state_q;
    bus.in_ready   = 1'b0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = 4'h0;
    busy           = 1'b1;
    done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = ADDR;
      end
      ADDR: begin
        bus.in_ready = 1'b1;
        if (acc) state_d = COUNT;
      end
      COUNT: begin
        bus.in_ready = 1'b1;
        if (acc) state_d = cnt_bad ? DONE : DATA;
      end
      DATA: begin
        bus.in_ready = 1'b1;
        if (acc && idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.byteenable = 4'hF;
        state_d        = (remaining_q == 8'd1) ? CHECK : DATA;
      end
      CHECK: begin
        bus.in_ready = 1'b1;
        if (acc) state_d = RDBK;
      end
      RDBK: begin
        bus.chipselect = 1'b1;
        bus.byteenable = 4'hF;
        if (rd_left_q == 8'd1) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address, word assembly, checksums and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      cur_q       <= '0;
      n_q         <= '0;
      remaining_q <= '0;
      rd_left_q   <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      sum_q       <= '0;
      rb_sum_q    <= '0;
      exp_q       <= '0;
      rd_pend_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      rd_pend_q <= (state_q == RDBK);
      if (rd_pend_q) rb_sum_q <= rb_sum_nxt;
      unique case (state_q)
        IDLE: if (start) begin
          error_q  <= 1'b0;
          sum_q    <= '0;
          rb_sum_q <= '0;
          idx_q    <= '0;
        end
        ADDR: if (acc) begin
          base_q <= ADDR_WIDTH'(bus.in_data);
          cur_q  <= ADDR_WIDTH'(bus.in_data);
        end
        COUNT: if (acc) begin
          if (cnt_bad) error_q <= 1'b1;
          n_q         <= bus.in_data;
          remaining_q <= bus.in_data;
        end
        DATA: if (acc) begin
          word_q[{idx_q, 3'b000} +: 8] <= bus.in_data;
          sum_q <= sum_q + bus.in_data;
          idx_q <= idx_q + 2'd1;
        end
        WRITE: begin
          cur_q       <= addr_inc(cur_q);
          remaining_q <= remaining_q - 8'd1;
        end
        CHECK: if (acc) begin
          exp_q     <= bus.in_data;
          if (bus.in_data != sum_q) error_q <= 1'b1;
          cur_q     <= base_q;
          rd_left_q <= n_q;
        end
        RDBK: begin
          cur_q     <= addr_inc(cur_q);
          rd_left_q <= rd_left_q - 8'd1;
        end
        DRAIN: if (rb_sum_nxt != exp_q) error_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Self-checking bench for onchip_mem_loader: RAM model plus scoreboard of
// expected writes, readback addresses and done-time error values.
module tb_onchip_mem_loader;
  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, error;

  onchip_mem_loader_if #(.ADDR_WIDTH(7)) bus_if();

  onchip_mem_loader #(.ADDR_WIDTH(7), .DEPTH(128)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus_if),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] mem [0:127];
  logic [38:0] wr_q [$];
  logic [6:0]  rd_q [$];
  logic        err_q [$];
  logic [31:0] ld_words [0:7];

  logic [38:0] mon_w;
  logic [6:0]  mon_a;
  logic        mon_e;

  // Synchronous RAM model: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (bus_if.chipselect && bus_if.write) mem[bus_if.address] <= bus_if.writedata;
    if (bus_if.chipselect && !bus_if.write) bus_if.readdata <= mem[bus_if.address];
  end

  // Scoreboard: compare RAM accesses and done-time error against expectations.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.chipselect && bus_if.write) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: addr=%0h data=%h, required no write", bus_if.address, bus_if.writedata);
        end else begin
          mon_w = wr_q.pop_front();
          if ({bus_if.address, bus_if.writedata} !== mon_w || bus_if.byteenable !== 4'hF) begin
            errors++;
            $display("FAIL write: addr=%0h data=%h be=%h, required addr=%0h data=%h be=f",
                     bus_if.address, bus_if.writedata, bus_if.byteenable, mon_w[38:32], mon_w[31:0]);
          end
        end
      end
      if (bus_if.chipselect && !bus_if.write) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: addr=%0h, required no read", bus_if.address);
        end else begin
          mon_a = rd_q.pop_front();
          if (bus_if.address !== mon_a || bus_if.byteenable !== 4'hF) begin
            errors++;
            $display("FAIL read: addr=%0h be=%h, required addr=%0h be=f", bus_if.address, bus_if.byteenable, mon_a);
          end
        end
      end
      if (!bus_if.chipselect && (bus_if.byteenable !== 4'h0 || bus_if.write !== 1'b0)) begin
        checks++;
        errors++;
        $display("FAIL idle_strobes: be=%h write=%b, required be=0 write=0", bus_if.byteenable, bus_if.write);
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: error=%b, required no done", error);
        end else begin
          mon_e = err_q.pop_front();
          if (error !== mon_e) begin
            errors++;
            $display("FAIL done_error: error=%b, required %b", error, mon_e);
          end
        end
      end
    end
  end

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        start = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    bus_if.in_data  = b;
    bus_if.in_valid = 1'b1;
    n = 0;
    while (!bus_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus_if.in_ready) begin
      errors++;
      $display("FAIL byte_accept: in_ready never rose for byte %h, required acceptance", b);
    end
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input logic exp_err, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_done_timeout: done_cnt=%0d, required %0d", name, done_cnt, d0 + 1);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || error !== exp_err) begin
      errors++;
      $display("FAIL %s_after_done: busy=%b error=%b, required busy=0 error=%b", name, busy, error, exp_err);
    end
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: writes=%0d reads=%0d dones=%0d pending, required 0 0 0",
               name, wr_q.size(), rd_q.size(), err_q.size());
    end
  endtask

  task automatic do_load(input logic [6:0] base, input int n, input logic [7:0] chk_delta,
                         input bit gaps, input string name);
    logic [7:0] sum;
    logic [6:0] a;
    logic       exp_err;
    int         d0;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      a = base + 7'(i);
      wr_q.push_back({a, ld_words[i]});
      rd_q.push_back(a);
      sum = sum + ld_words[i][7:0] + ld_words[i][15:8] + ld_words[i][23:16] + ld_words[i][31:24];
    end
    exp_err = (chk_delta != 8'd0);
    err_q.push_back(exp_err);
    d0 = done_cnt;
    start_load();
    send_byte({1'b0, base}, gaps);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++)
        send_byte(ld_words[i][8*j +: 8], gaps);
    send_byte(sum + chk_delta, gaps);
    wait_done(d0, exp_err, name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus_if.in_data  = 8'h00;
    bus_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.in_ready, bus_if.chipselect, bus_if.write, busy, done, error} !== 6'b0 ||
        bus_if.address !== 7'h0 || bus_if.writedata !== 32'h0 ||
        bus_if.byteenable !== 4'h0 || bus_if.clken !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: rdy=%b cs=%b wr=%b busy=%b done=%b err=%b addr=%h wd=%h be=%h clken=%b, required all 0, clken=1",
               bus_if.in_ready, bus_if.chipselect, bus_if.write, busy, done, error,
               bus_if.address, bus_if.writedata, bus_if.byteenable, bus_if.clken);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    ld_words[0] = 32'h04030201;
    ld_words[1] = 32'h08070605;
    do_load(7'h10, 2, 8'h00, 1'b0, "basic");
    do_load(7'h10, 2, 8'h01, 1'b0, "bad_checksum");
  endtask

  task automatic test_wrap();
    ld_words[0] = 32'hDEADBEEF;
    ld_words[1] = 32'h12345678;
    do_load(7'h7F, 2, 8'h00, 1'b0, "wrap");
  endtask

  task automatic test_bad_count(input logic [7:0] cnt, input string name);
    int d0;
    err_q.push_back(1'b1);
    d0 = done_cnt;
    start_load();
    send_byte(8'h20, 1'b0);
    send_byte(cnt, 1'b0);
    wait_done(d0, 1'b1, name);
  endtask

  task automatic test_reset_midload();
    start_load();
    send_byte(8'h10, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus_if.write !== 1'b0 || bus_if.in_ready !== 1'b0 ||
        bus_if.chipselect !== 1'b0 || bus_if.address !== 7'h0 ||
        bus_if.writedata !== 32'h0 || error !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: busy=%b wr=%b rdy=%b cs=%b addr=%h wd=%h err=%b done=%b, required all 0",
               busy, bus_if.write, bus_if.in_ready, bus_if.chipselect,
               bus_if.address, bus_if.writedata, error, done);
    end
    reset = 1'b0;
    ld_words[0] = 32'h11223344;
    ld_words[1] = 32'h55667788;
    ld_words[2] = 32'h99AABBCC;
    do_load(7'h40, 3, 8'h00, 1'b0, "after_reset");
  endtask

  task automatic test_gaps();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) ld_words[i] = $urandom;
      do_load(7'($urandom_range(0, 127)), $urandom_range(1, 8), 8'h00, 1'b1, "gaps");
    end
    for (int i = 0; i < 3; i++) ld_words[i] = $urandom;
    do_load(7'h7E, 3, 8'h80, 1'b1, "gaps_bad_chk");
  endtask

  task automatic test_back_to_back();
    ld_words[0] = 32'hCAFEF00D;
    do_load(7'h00, 1, 8'h00, 1'b0, "b2b_first");
    ld_words[0] = 32'h0BADBEEF;
    ld_words[1] = 32'h00000000;
    do_load(7'h01, 2, 8'h00, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_count(8'h00, "count_zero");
    test_bad_count(8'h81, "count_big");
    test_reset_midload();
    test_gaps();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
